// File: rtl/equal_multi_pkg.sv
// equal_multi_pkg: shared state encoding and width helpers for the temporal equal operator
package equal_multi_pkg;
  typedef enum logic [1:0] {WAIT, WINDOW, FIRE, DONE} eq_state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/equal_multi_if.sv
// equal_multi_if: event inputs, per-cycle configuration and result outputs of equal_multi
interface equal_multi_if #(
  parameter int NUM_IN            = 4,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int TOL_WIDTH         = 4
);
  logic [NUM_IN-1:0]            in;
  logic [NUM_IN-1:0]            en_mask;
  logic [TOL_WIDTH-1:0]         tol;
  logic                         y;
  logic                         hit;
  logic                         done;
  logic [GAMMA_CYCLE_WIDTH-1:0] t_out;
  modport master (output in, en_mask, tol, input y, hit, done, t_out);
  modport slave  (input in, en_mask, tol, output y, hit, done, t_out);
endinterface

// File: rtl/equal_multi_pulse_gen.sv
// pulse_gen: start-triggered fixed-width registered pulse with synchronous clear
module pulse_gen
  import equal_multi_pkg::*;
#(
  parameter int PULSE_WIDTH = 8
) (
  input  logic aclk,
  input  logic grst_n,
  input  logic clr,
  input  logic start,
  output logic busy,
  output logic y
);
  localparam int CW = cnt_w(PULSE_WIDTH);
  logic          r_y;
  logic [CW-1:0] r_cnt;
  if (PULSE_WIDTH < 1) begin : g_bad_pw
    $error("PULSE_WIDTH must be >= 1");
  end
  always_ff @(posedge aclk or negedge grst_n)
    if (!grst_n) begin
      r_y   <= 1'b0;
      r_cnt <= '0;
    end else if (clr) begin
      r_y   <= 1'b0;
      r_cnt <= '0;
    end else if (start) begin
      r_y   <= 1'b1;
      r_cnt <= CW'(PULSE_WIDTH - 1);
    end else if (r_y) begin
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      else r_y <= 1'b0;
    end
  // busy drops in the last high cycle so the owner can leave exactly as the pulse ends
  assign busy = r_y && (r_cnt != '0);
  assign y    = r_y;
endmodule

// File: rtl/equal_multi.sv
// equal_multi: N-input temporal equal with arrival tolerance, masking and first-arrival stamp
module equal_multi
  import equal_multi_pkg::*;
#(
  parameter int NUM_IN            = 4,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int TOL_WIDTH         = 4
) (
  input  logic         aclk,
  input  logic         grst_n,
  input  logic         rst,
  equal_multi_if.slave bus
);
  eq_state_t                    r_state, w_next;
  logic [NUM_IN-1:0]            r_arrived, w_eff;
  logic [GAMMA_CYCLE_WIDTH-1:0] r_t, r_t_out;
  logic [TOL_WIDTH:0]           r_win_cnt, w_elapsed;
  logic                         r_hit, w_all_in, w_start, w_busy, w_y;
  if (NUM_IN < 2) begin : g_bad_num
    $error("NUM_IN must be >= 2");
  end
  assign w_eff     = (r_arrived | bus.in) & bus.en_mask;
  assign w_all_in  = (w_eff == bus.en_mask) && (|bus.en_mask);
  // cycles elapsed since the first arrival, so t_first+tol is still inside the window
  assign w_elapsed = r_win_cnt + 1'b1;
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      WAIT:
        if (|w_eff) begin
          w_next  = w_all_in ? FIRE : WINDOW;
          w_start = w_all_in;
        end
      WINDOW:
        if (w_all_in && (w_elapsed <= {1'b0, bus.tol})) begin
          w_next  = FIRE;
          w_start = 1'b1;
        end else if (w_elapsed >= {1'b0, bus.tol}) w_next = DONE;
      FIRE: w_next = w_busy ? FIRE : DONE;
      default: ;
    endcase
  end
  always_ff @(posedge aclk or negedge grst_n)
    if (!grst_n) begin
      r_state   <= WAIT;
      r_arrived <= '0;
      r_t       <= '0;
      r_t_out   <= '0;
      r_win_cnt <= '0;
      r_hit     <= 1'b0;
    end else if (rst) begin
      r_state   <= WAIT;
      r_arrived <= '0;
      r_t       <= '0;
      r_t_out   <= '0;
      r_win_cnt <= '0;
      r_hit     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_arrived <= r_arrived | bus.in;
      r_t       <= (&r_t) ? r_t : r_t + 1'b1;
      if (r_state == WAIT && w_next != WAIT) begin
        r_t_out   <= r_t;
        r_win_cnt <= '0;
      end else if (r_state == WINDOW) r_win_cnt <= r_win_cnt + 1'b1;
      if (w_start) r_hit <= 1'b1;
    end
  pulse_gen #(.PULSE_WIDTH(PULSE_WIDTH)) u_pulse (
    .aclk   (aclk),
    .grst_n (grst_n),
    .clr    (rst),
    .start  (w_start),
    .busy   (w_busy),
    .y      (w_y)
  );
  assign bus.y     = w_y;
  assign bus.hit   = r_hit;
  assign bus.done  = (r_state == DONE);
  assign bus.t_out = r_t_out;
endmodule

// File: tb/tb_equal_multi.sv
// tb_equal_multi: scoreboard bench for equal_multi, per-cycle expectations built from scenario timing
module tb_equal_multi;
  localparam int NEVER = 1000;
  typedef struct {
    int          t;
    logic        y;
    logic        hit;
    logic        done;
    logic [15:0] t_out;
  } exp_t;
  logic aclk = 1'b0;
  logic grst_n = 1'b0;
  logic rst = 1'b0;
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  equal_multi_if #(.NUM_IN(4), .GAMMA_CYCLE_WIDTH(16), .TOL_WIDTH(4)) bus ();
  equal_multi #(.NUM_IN(4), .GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8), .TOL_WIDTH(4)) dut (
    .aclk   (aclk),
    .grst_n (grst_n),
    .rst    (rst),
    .bus    (bus.slave)
  );
  always #5 aclk = ~aclk;
  task automatic push_exp(input int t, input int ys, input int ye, input int df, input int tf);
    exp_t x;
    x.t     = t;
    x.y     = (t >= ys) && (t <= ye);
    x.hit   = (t >= ys);
    x.done  = (t >= df);
    x.t_out = (t > tf) ? 16'(tf) : 16'd0;
    sb.push_back(x);
  endtask
  task automatic drive(input int t, input int a0, input int a1, input int a2, input int a3);
    bus.in = {t >= a3, t >= a2, t >= a1, t >= a0};
  endtask
  task automatic start_gamma(input logic [3:0] m, input logic [3:0] tl);
    bus.in = '0;
    bus.en_mask = m;
    bus.tol = tl;
    rst = 1'b1;
    @(negedge aclk);
    rst = 1'b0;
  endtask
  task automatic test_reset();
    exp_t x;
    bus.in = '0;
    bus.en_mask = 4'hF;
    bus.tol = 4'd0;
    repeat (2) @(negedge aclk);
    total++;
    if (bus.y !== 1'b0 || bus.hit !== 1'b0 || bus.done !== 1'b0 || bus.t_out !== 16'd0) begin
      bad++;
      $display("FAIL reset_hold got y=%b hit=%b done=%b t_out=%0d want all 0", bus.y, bus.hit, bus.done, bus.t_out);
    end
    grst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      push_exp(t, NEVER, NEVER, NEVER, NEVER);
      x = sb.pop_front();
      total++;
      if (bus.y !== x.y || bus.hit !== x.hit || bus.done !== x.done || bus.t_out !== x.t_out) begin
        bad++;
        $display("FAIL reset_idle t=%0d got y=%b hit=%b done=%b t_out=%0d want y=%b hit=%b done=%b t_out=%0d", x.t, bus.y, bus.hit, bus.done, bus.t_out, x.y, x.hit, x.done, x.t_out);
      end
      @(negedge aclk);
    end
  endtask
  task automatic test_strict();
    exp_t x;
    start_gamma(4'hF, 4'd0);
    for (int t = 0; t < 18; t++) begin
      drive(t, 5, 5, 5, 5);
      push_exp(t, 6, 13, 14, 5);
      x = sb.pop_front();
      total++;
      if (bus.y !== x.y || bus.hit !== x.hit || bus.done !== x.done || bus.t_out !== x.t_out) begin
        bad++;
        $display("FAIL strict t=%0d got y=%b hit=%b done=%b t_out=%0d want y=%b hit=%b done=%b t_out=%0d", x.t, bus.y, bus.hit, bus.done, bus.t_out, x.y, x.hit, x.done, x.t_out);
      end
      @(negedge aclk);
    end
  endtask
  task automatic test_tolerance();
    exp_t x;
    start_gamma(4'hF, 4'd3);
    for (int t = 0; t < 18; t++) begin
      drive(t, 2, 3, 4, 5);
      push_exp(t, 6, 13, 14, 2);
      x = sb.pop_front();
      total++;
      if (bus.y !== x.y || bus.hit !== x.hit || bus.done !== x.done || bus.t_out !== x.t_out) begin
        bad++;
        $display("FAIL tol_within t=%0d got y=%b hit=%b done=%b t_out=%0d want y=%b hit=%b done=%b t_out=%0d", x.t, bus.y, bus.hit, bus.done, bus.t_out, x.y, x.hit, x.done, x.t_out);
      end
      @(negedge aclk);
    end
    start_gamma(4'hF, 4'd3);
    for (int t = 0; t < 14; t++) begin
      drive(t, 2, 2, 2, 6);
      push_exp(t, NEVER, NEVER, 6, 2);
      x = sb.pop_front();
      total++;
      if (bus.y !== x.y || bus.hit !== x.hit || bus.done !== x.done || bus.t_out !== x.t_out) begin
        bad++;
        $display("FAIL tol_exceed t=%0d got y=%b hit=%b done=%b t_out=%0d want y=%b hit=%b done=%b t_out=%0d", x.t, bus.y, bus.hit, bus.done, bus.t_out, x.y, x.hit, x.done, x.t_out);
      end
      @(negedge aclk);
    end
    start_gamma(4'hF, 4'd0);
    for (int t = 0; t < 10; t++) begin
      drive(t, 3, 3, 3, 4);
      push_exp(t, NEVER, NEVER, 5, 3);
      x = sb.pop_front();
      total++;
      if (bus.y !== x.y || bus.hit !== x.hit || bus.done !== x.done || bus.t_out !== x.t_out) begin
        bad++;
        $display("FAIL tol_zero_fail t=%0d got y=%b hit=%b done=%b t_out=%0d want y=%b hit=%b done=%b t_out=%0d", x.t, bus.y, bus.hit, bus.done, bus.t_out, x.y, x.hit, x.done, x.t_out);
      end
      @(negedge aclk);
    end
  endtask
  task automatic test_mask();
    exp_t x;
    start_gamma(4'b0101, 4'd0);
    for (int t = 0; t < 20; t++) begin
      drive(t, 7, NEVER, 7, NEVER);
      bus.in[1] = 1'($urandom_range(0, 1));
      bus.in[3] = 1'($urandom_range(0, 1));
      push_exp(t, 8, 15, 16, 7);
      x = sb.pop_front();
      total++;
      if (bus.y !== x.y || bus.hit !== x.hit || bus.done !== x.done || bus.t_out !== x.t_out) begin
        bad++;
        $display("FAIL mask_0101 t=%0d got y=%b hit=%b done=%b t_out=%0d want y=%b hit=%b done=%b t_out=%0d", x.t, bus.y, bus.hit, bus.done, bus.t_out, x.y, x.hit, x.done, x.t_out);
      end
      @(negedge aclk);
    end
    start_gamma(4'b0000, 4'd0);
    for (int t = 0; t < 100; t++) begin
      bus.in = 4'($urandom_range(0, 15));
      push_exp(t, NEVER, NEVER, NEVER, NEVER);
      x = sb.pop_front();
      total++;
      if (bus.y !== x.y || bus.hit !== x.hit || bus.done !== x.done || bus.t_out !== x.t_out) begin
        bad++;
        $display("FAIL mask_zero t=%0d got y=%b hit=%b done=%b t_out=%0d want y=%b hit=%b done=%b t_out=%0d", x.t, bus.y, bus.hit, bus.done, bus.t_out, x.y, x.hit, x.done, x.t_out);
      end
      @(negedge aclk);
    end
  endtask
  task automatic test_single();
    exp_t x;
    start_gamma(4'b0010, 4'd0);
    for (int t = 0; t < 16; t++) begin
      drive(t, NEVER, 4, NEVER, NEVER);
      push_exp(t, 5, 12, 13, 4);
      x = sb.pop_front();
      total++;
      if (bus.y !== x.y || bus.hit !== x.hit || bus.done !== x.done || bus.t_out !== x.t_out) begin
        bad++;
        $display("FAIL single t=%0d got y=%b hit=%b done=%b t_out=%0d want y=%b hit=%b done=%b t_out=%0d", x.t, bus.y, bus.hit, bus.done, bus.t_out, x.y, x.hit, x.done, x.t_out);
      end
      @(negedge aclk);
    end
  endtask
  task automatic test_rst_mid_pulse();
    exp_t x;
    start_gamma(4'hF, 4'd0);
    for (int t = 0; t < 8; t++) begin
      drive(t, 4, 4, 4, 4);
      push_exp(t, 5, 12, 13, 4);
      x = sb.pop_front();
      total++;
      if (bus.y !== x.y || bus.hit !== x.hit || bus.done !== x.done || bus.t_out !== x.t_out) begin
        bad++;
        $display("FAIL rst_pre t=%0d got y=%b hit=%b done=%b t_out=%0d want y=%b hit=%b done=%b t_out=%0d", x.t, bus.y, bus.hit, bus.done, bus.t_out, x.y, x.hit, x.done, x.t_out);
      end
      if (t == 7) rst = 1'b1;
      @(negedge aclk);
    end
    rst = 1'b0;
    for (int t = 0; t < 12; t++) begin
      drive(t, 0, 0, 0, 0);
      push_exp(t, 1, 8, 9, 0);
      x = sb.pop_front();
      total++;
      if (bus.y !== x.y || bus.hit !== x.hit || bus.done !== x.done || bus.t_out !== x.t_out) begin
        bad++;
        $display("FAIL rst_held t=%0d got y=%b hit=%b done=%b t_out=%0d want y=%b hit=%b done=%b t_out=%0d", x.t, bus.y, bus.hit, bus.done, bus.t_out, x.y, x.hit, x.done, x.t_out);
      end
      @(negedge aclk);
    end
    start_gamma(4'hF, 4'd0);
    for (int t = 0; t < 12; t++) begin
      drive(t, 1, 1, 1, 1);
      push_exp(t, 2, 9, 10, 1);
      x = sb.pop_front();
      total++;
      if (bus.y !== x.y || bus.hit !== x.hit || bus.done !== x.done || bus.t_out !== x.t_out) begin
        bad++;
        $display("FAIL rst_refire t=%0d got y=%b hit=%b done=%b t_out=%0d want y=%b hit=%b done=%b t_out=%0d", x.t, bus.y, bus.hit, bus.done, bus.t_out, x.y, x.hit, x.done, x.t_out);
      end
      @(negedge aclk);
    end
  endtask
  task automatic test_async_reset();
    exp_t x;
    start_gamma(4'hF, 4'd5);
    for (int t = 0; t < 5; t++) begin
      drive(t, 2, NEVER, NEVER, NEVER);
      push_exp(t, NEVER, NEVER, NEVER, 2);
      x = sb.pop_front();
      total++;
      if (bus.y !== x.y || bus.hit !== x.hit || bus.done !== x.done || bus.t_out !== x.t_out) begin
        bad++;
        $display("FAIL async_window t=%0d got y=%b hit=%b done=%b t_out=%0d want y=%b hit=%b done=%b t_out=%0d", x.t, bus.y, bus.hit, bus.done, bus.t_out, x.y, x.hit, x.done, x.t_out);
      end
      @(negedge aclk);
    end
    #2 grst_n = 1'b0;
    #1;
    total++;
    if (bus.y !== 1'b0 || bus.hit !== 1'b0 || bus.done !== 1'b0 || bus.t_out !== 16'd0) begin
      bad++;
      $display("FAIL async_drop_window got y=%b hit=%b done=%b t_out=%0d want all 0", bus.y, bus.hit, bus.done, bus.t_out);
    end
    bus.in = '0;
    bus.tol = 4'd0;
    @(negedge aclk);
    grst_n = 1'b1;
    for (int t = 0; t < 7; t++) begin
      drive(t, 3, 3, 3, 3);
      push_exp(t, 4, 11, 12, 3);
      x = sb.pop_front();
      total++;
      if (bus.y !== x.y || bus.hit !== x.hit || bus.done !== x.done || bus.t_out !== x.t_out) begin
        bad++;
        $display("FAIL async_fire t=%0d got y=%b hit=%b done=%b t_out=%0d want y=%b hit=%b done=%b t_out=%0d", x.t, bus.y, bus.hit, bus.done, bus.t_out, x.y, x.hit, x.done, x.t_out);
      end
      @(negedge aclk);
    end
    #2 grst_n = 1'b0;
    #1;
    total++;
    if (bus.y !== 1'b0 || bus.hit !== 1'b0 || bus.done !== 1'b0 || bus.t_out !== 16'd0) begin
      bad++;
      $display("FAIL async_drop_fire got y=%b hit=%b done=%b t_out=%0d want all 0", bus.y, bus.hit, bus.done, bus.t_out);
    end
    bus.in = '0;
    @(negedge aclk);
    grst_n = 1'b1;
    for (int t = 0; t < 14; t++) begin
      drive(t, 3, 3, 3, 3);
      push_exp(t, 4, 11, 12, 3);
      x = sb.pop_front();
      total++;
      if (bus.y !== x.y || bus.hit !== x.hit || bus.done !== x.done || bus.t_out !== x.t_out) begin
        bad++;
        $display("FAIL async_fresh t=%0d got y=%b hit=%b done=%b t_out=%0d want y=%b hit=%b done=%b t_out=%0d", x.t, bus.y, bus.hit, bus.done, bus.t_out, x.y, x.hit, x.done, x.t_out);
      end
      @(negedge aclk);
    end
  endtask
  initial begin
    bus.in = '0;
    bus.en_mask = '0;
    bus.tol = '0;
    test_reset();
    test_strict();
    test_tolerance();
    test_mask();
    test_single();
    test_rst_mid_pulse();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
